// File: rtl/fetch_queue_if.sv
// Prefetch-to-decoder bus of the fetch queue.
// The master modport is the prefetcher/decoder side; the slave modport is the queue itself.
interface fetch_queue_if;
  logic        in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_len;
  logic        in_limit;
  logic        in_page_fault;
  logic        in_ready;
  logic [63:0] fetch;
  logic [3:0]  fetch_valid;
  logic        fetch_limit;
  logic        fetch_page_fault;
  logic [3:0]  dec_acceptable;

  modport master (
    output in_valid, in_data, in_len, in_limit, in_page_fault, dec_acceptable,
    input  in_ready, fetch, fetch_valid, fetch_limit, fetch_page_fault
  );

  modport slave (
    input  in_valid, in_data, in_len, in_limit, in_page_fault, dec_acceptable,
    output in_ready, fetch, fetch_valid, fetch_limit, fetch_page_fault
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: 16-byte shift buffer between the prefetcher and the decoder.
// Up to 8 bytes enter per cycle, up to 8 leave per cycle, and both can happen in the same cycle.
// Entries carrying a CS-limit or page-fault marker halt intake.
// The marker becomes visible to the decoder once the queue has drained.
module fetch_queue (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pr_reset,
  fetch_queue_if.slave bus
);

  typedef enum logic [1:0] {RUN, HALT_LIMIT, HALT_PF} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [7:0]  r_mem [16];

  logic [7:0]  w_mem_next [16];
  logic [7:0]  w_in_byte [8];
  logic [3:0]  w_fv;
  logic [3:0]  w_len;
  logic [3:0]  w_k;
  logic        w_push;
  logic [4:0]  w_base;
  logic [4:0]  w_cnt_next;

  // Decoder-visible window is the oldest min(cnt, 8) bytes.
  assign w_fv  = (r_cnt > 5'd8) ? 4'd8 : r_cnt[3:0];
  // Lengths above 8 saturate to a full entry.
  assign w_len = (bus.in_len > 4'd8) ? 4'd8 : bus.in_len;
  // Bytes consumed this cycle can never exceed what is presented.
  assign w_k   = (bus.dec_acceptable < w_fv) ? bus.dec_acceptable : w_fv;

  // Intake only in RUN, outside flush, with room for a full 8-byte entry.
  // Gating with rst_n keeps in_ready low while reset is held.
  assign bus.in_ready = rst_n && (r_state == RUN) && !pr_reset && (r_cnt <= 5'd8);
  assign w_push       = bus.in_valid && bus.in_ready;

  // New bytes land directly behind what survives this cycle's removal.
  assign w_base     = r_cnt - {1'b0, w_k};
  assign w_cnt_next = w_base + (w_push ? {1'b0, w_len} : 5'd0);

  assign bus.fetch_valid      = w_fv;
  assign bus.fetch_limit      = (r_state == HALT_LIMIT) && (r_cnt == 5'd0);
  assign bus.fetch_page_fault = (r_state == HALT_PF) && (r_cnt == 5'd0);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bytes_io
      assign w_in_byte[gi]         = bus.in_data[gi*8 +: 8];
      assign bus.fetch[gi*8 +: 8]  = r_mem[gi];
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
      localparam logic [4:0] LP_POS = 5'(gi);
      logic [4:0] w_src;
      logic [4:0] w_off;
      logic       w_take_new;
      // Slot gi receives either an incoming byte or the byte k positions above it.
      assign w_src      = LP_POS + {1'b0, w_k};
      assign w_off      = LP_POS - w_base;
      assign w_take_new = w_push && (LP_POS >= w_base) && (w_off < {1'b0, w_len});
      assign w_mem_next[gi] = w_take_new     ? w_in_byte[w_off[2:0]] :
                              (w_src < 5'd16) ? r_mem[w_src[3:0]]    :
                                                r_mem[gi];
    end
  endgenerate

  // Occupancy and byte storage; flush empties the queue and drops this cycle's push/removal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 5'd0;
      for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
    end else if (pr_reset) begin
      r_cnt <= 5'd0;
    end else begin
      r_cnt <= w_cnt_next;
      for (int i = 0; i < 16; i++) r_mem[i] <= w_mem_next[i];
    end
  end

  // Halt FSM: a marker entry is appended, then intake stops until flush; page fault wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else if (pr_reset) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_push && bus.in_page_fault)  r_state <= HALT_PF;
          else if (w_push && bus.in_limit)  r_state <= HALT_LIMIT;
        end
        HALT_LIMIT: r_state <= HALT_LIMIT;
        HALT_PF:    r_state <= HALT_PF;
        default:    r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a byte-queue scoreboard model plus a table of
// hand-derived expectations, directed reset sequences and a short random run.
module tb_fetch_queue;

  logic clk;
  logic rst_n;
  logic pr_reset;

  fetch_queue_if bus ();

  fetch_queue u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pr_reset (pr_reset),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  len;
    logic        lim;
    logic        pf;
    logic [3:0]  dec;
    logic        pr;
    logic [3:0]  e_fv;
    logic        e_rdy;
    logic        e_lim;
    logic        e_pf;
    logic [63:0] e_mask;
    logic [63:0] e_fetch;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Scoreboard: bytes expected in order, and the expected halt state (0 RUN, 1 LIMIT, 2 PF).
  logic [7:0] mq [$];
  int         m_state = 0;
  logic [7:0] next_byte = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [3:0] len, input logic lim,
                              input logic pf, input logic [3:0] dec, input logic pr,
                              input logic [3:0] e_fv, input logic e_rdy, input logic e_lim,
                              input logic e_pf, input logic [63:0] e_mask,
                              input logic [63:0] e_fetch);
    vec_t v;
    v.vld = vld; v.len = len; v.lim = lim; v.pf = pf; v.dec = dec; v.pr = pr;
    v.e_fv = e_fv; v.e_rdy = e_rdy; v.e_lim = e_lim; v.e_pf = e_pf;
    v.e_mask = e_mask; v.e_fetch = e_fetch;
    return v;
  endfunction

  task automatic drive_idle();
    bus.in_valid       = 1'b0;
    bus.in_data        = 64'h0;
    bus.in_len         = 4'd0;
    bus.in_limit       = 1'b0;
    bus.in_page_fault  = 1'b0;
    bus.dec_acceptable = 4'd0;
    pr_reset           = 1'b0;
  endtask

  // Compare DUT outputs against the scoreboard (inputs idle, between edges).
  task automatic check_model(input string tag);
    int sz;
    int fv;
    logic [63:0] f;
    sz = mq.size();
    fv = (sz > 8) ? 8 : sz;
    f  = bus.fetch;
    chk({tag, "_fetch_valid"}, 64'(bus.fetch_valid), 64'(fv));
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'((m_state == 0) && (sz <= 8)));
    chk({tag, "_fetch_limit"}, 64'(bus.fetch_limit), 64'((m_state == 1) && (sz == 0)));
    chk({tag, "_fetch_pf"}, 64'(bus.fetch_page_fault), 64'((m_state == 2) && (sz == 0)));
    for (int j = 0; j < fv; j++)
      chk({tag, "_byte"}, 64'(f[j*8 +: 8]), 64'(mq[j]));
  endtask

  // One cycle: drive inputs, update the scoreboard, clock, then return to idle inputs.
  task automatic apply(input logic vld, input logic [3:0] len, input logic lim,
                       input logic pf, input logic [3:0] dec, input logic pr);
    int sz;
    int fv;
    int k;
    int lsat;
    logic mrdy;
    logic push;
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[j*8 +: 8] = next_byte + 8'(j);
    bus.in_valid       = vld;
    bus.in_data        = d;
    bus.in_len         = len;
    bus.in_limit       = lim;
    bus.in_page_fault  = pf;
    bus.dec_acceptable = dec;
    pr_reset           = pr;
    sz   = mq.size();
    fv   = (sz > 8) ? 8 : sz;
    k    = (int'(dec) < fv) ? int'(dec) : fv;
    lsat = (len > 4'd8) ? 8 : int'(len);
    mrdy = (m_state == 0) && !pr && (sz <= 8);
    push = vld && mrdy;
    #1;
    chk("in_ready_live", 64'(bus.in_ready), 64'(mrdy));
    if (pr) begin
      mq.delete();
      m_state = 0;
    end else begin
      for (int j = 0; j < k; j++) void'(mq.pop_front());
      if (push) begin
        for (int j = 0; j < lsat; j++) mq.push_back(next_byte + 8'(j));
        next_byte = next_byte + 8'(lsat);
        if (pf) m_state = 2;
        else if (lim) m_state = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1;
  endtask

  vec_t vecs [$];

  initial begin
    drive_idle();
    rst_n = 1'b0;

    vecs.push_back(mk(1, 8,  0, 0, 0, 0, 8, 1, 0, 0, 64'h0, 64'h0));                  // fill half
    vecs.push_back(mk(1, 8,  0, 0, 0, 0, 8, 0, 0, 0, {64{1'b1}}, 64'h0706050403020100)); // full
    vecs.push_back(mk(1, 8,  0, 0, 3, 0, 8, 0, 0, 0, 64'h0, 64'h0));                  // refused push
    vecs.push_back(mk(0, 0,  0, 0, 8, 0, 5, 1, 0, 0, 64'h0, 64'h0));                  // drain to 5
    vecs.push_back(mk(1, 4,  0, 0, 3, 0, 6, 1, 0, 0, 64'h0000_FFFF_FFFF_FFFF, 64'h0000_1312_1110_0F0E)); // push+remove
    vecs.push_back(mk(0, 0,  0, 0, 8, 0, 0, 1, 0, 0, 64'h0, 64'h0));                  // empty
    vecs.push_back(mk(1, 2,  1, 0, 0, 0, 2, 0, 0, 0, 64'h0, 64'h0));                  // limit entry
    vecs.push_back(mk(0, 0,  0, 0, 8, 0, 0, 0, 1, 0, 64'h0, 64'h0));                  // limit visible
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0, 1, 0, 0, 64'h0, 64'h0));                  // flush
    vecs.push_back(mk(1, 0,  1, 1, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0));                  // pf wins
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0, 1, 0, 0, 64'h0, 64'h0));                  // flush
    vecs.push_back(mk(1, 8,  0, 0, 0, 0, 8, 1, 0, 0, 64'h0, 64'h0));                  // cnt 8
    vecs.push_back(mk(1, 4,  1, 0, 0, 0, 8, 0, 0, 0, 64'h0, 64'h0));                  // cnt 12 halted
    vecs.push_back(mk(1, 8,  0, 0, 8, 1, 0, 1, 0, 0, 64'h0, 64'h0));                  // flush wins
    vecs.push_back(mk(1, 15, 0, 0, 0, 0, 8, 1, 0, 0, {64{1'b1}}, 64'h2928272625242322)); // len saturates
    vecs.push_back(mk(0, 0,  0, 0, 2, 0, 6, 1, 0, 0, 64'h0, 64'h0));                  // cnt 6
    vecs.push_back(mk(1, 3,  0, 0, 8, 0, 3, 1, 0, 0, 64'h0000_0000_00FF_FFFF, 64'h0000_0000_002C_2B2A)); // cnt 3

    // Reset held: everything quiet, in_ready low.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_fetch_limit", 64'(bus.fetch_limit), 64'd0);
    chk("rst_fetch_pf", 64'(bus.fetch_page_fault), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_model("post_rst");

    foreach (vecs[i]) begin
      apply(vecs[i].vld, vecs[i].len, vecs[i].lim, vecs[i].pf, vecs[i].dec, vecs[i].pr);
      check_model($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_fv", i), 64'(bus.fetch_valid), 64'(vecs[i].e_fv));
      chk($sformatf("vec%0d_rdy", i), 64'(bus.in_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_lim", i), 64'(bus.fetch_limit), 64'(vecs[i].e_lim));
      chk($sformatf("vec%0d_pf", i), 64'(bus.fetch_page_fault), 64'(vecs[i].e_pf));
      if (vecs[i].e_mask != 64'h0)
        chk($sformatf("vec%0d_fetch", i), bus.fetch & vecs[i].e_mask, vecs[i].e_fetch);
      $display("vec %0d: fetch_valid=%0d in_ready=%0b limit=%0b pf=%0b fetch=%h",
               i, bus.fetch_valid, bus.in_ready, bus.fetch_limit, bus.fetch_page_fault, bus.fetch);
    end

    // Asynchronous reset mid-cycle with 9 bytes queued.
    apply(1, 8, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0);
    chk("cnt9_fetch_valid", 64'(bus.fetch_valid), 64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
    mq.delete();
    m_state = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_model("after_async_rst");
    $display("async reset: fetch_valid=%0d in_ready=%0b", bus.fetch_valid, bus.in_ready);

    // Random traffic against the scoreboard.
    for (int n = 0; n < 80; n++) begin
      apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0),
            4'($urandom_range(0, 8)), 1'($urandom_range(0, 9) == 0));
      check_model($sformatf("rnd%0d", n));
      $display("rnd %0d: queued=%0d state=%0d fetch_valid=%0d", n, mq.size(), m_state, bus.fetch_valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port pr_reset, input, 1 bit: synchronous flush on control-transfer or prefetch restart.
REQ-004 SHALL have port in_valid, input, 1 bit: prefetch entry offered.
REQ-005 SHALL have port in_data, input, 64 bits: entry bytes, little-endian; byte 0 is in_data[7:0] and is the earliest in program order.
REQ-006 SHALL have port in_len, input, 4 bits: valid bytes in the entry, 0..8; values above 8 are treated as 8.
REQ-007 SHALL have port in_limit, input, 1 bit: entry carries a CS-limit marker.
REQ-008 SHALL have port in_page_fault, input, 1 bit: entry carries a page-fault marker.
REQ-009 SHALL have port in_ready, output, 1 bit: the entry is taken this cycle when in_valid && in_ready.
REQ-010 SHALL have port fetch, output, 64 bits: oldest 8 queued bytes, byte 0 in [7:0].
REQ-011 SHALL have port fetch_valid, output, 4 bits: number of valid bytes on fetch, 0..8.
REQ-012 SHALL have port fetch_limit, output, 1 bit: limit marker reached and the queue is empty.
REQ-013 SHALL have port fetch_page_fault, output, 1 bit: page-fault marker reached and the queue is empty.
REQ-014 SHALL have port dec_acceptable, input, 4 bits: bytes the decoder takes this cycle, 0..8.

Function
REQ-015 SHALL hold a 16-byte storage array and a 5-bit occupancy counter cnt, range 0..16.
REQ-016 SHALL drive fetch_valid as min(cnt, 8) and fetch as storage bytes 0..7; bytes at or beyond cnt are don't-care.
REQ-017 SHALL compute the number of bytes removed as k = min(fetch_valid, dec_acceptable), and SHALL apply k in the same cycle.
REQ-018 SHALL, on removal, shift the remaining bytes down by k so that the oldest remaining byte lands at position 0.
REQ-019 SHALL assert in_ready only when the FSM is in RUN, pr_reset = 0, and cnt + 8 <= 16.
REQ-020 SHALL, on push, append in_len bytes at position cnt - k, so that a push and a removal in the same cycle are both honoured.
REQ-021 SHALL update cnt as cnt - k + (push ? in_len : 0), with no overflow or underflow possible given REQ-019.
REQ-022 SHALL implement an FSM with states RUN, HALT_LIMIT and HALT_PF.
REQ-023 SHALL, on a push with in_page_fault = 1, go RUN -> HALT_PF; in_page_fault takes priority if both markers are set.
REQ-024 SHALL, on a push with only in_limit = 1, go RUN -> HALT_LIMIT.
REQ-025 SHALL still append the in_len bytes of a marker entry before halting.
REQ-026 SHALL keep in_ready = 0 in the HALT states, so no further pushes occur.
REQ-027 SHALL continue to drain bytes to the decoder while in a HALT state.
REQ-028 SHALL drive fetch_limit = (state == HALT_LIMIT) && cnt == 0.
REQ-029 SHALL drive fetch_page_fault = (state == HALT_PF) && cnt == 0.
REQ-030 SHALL, on pr_reset, set cnt to 0 and the state to RUN at the next edge, discarding any push or removal in that cycle.
REQ-031 SHALL give pr_reset priority over all other events.
REQ-032 SHALL provide zero-cycle output latency: fetch and fetch_valid are registered-state decodes, with no combinational path from in_* to fetch*.
REQ-033 SHALL have a combinational path from dec_acceptable only into next-state logic.

Reset
REQ-034 SHALL, while rst_n = 0, asynchronously force cnt = 0 and state = RUN.
REQ-035 SHALL therefore hold fetch_valid = 0, fetch_limit = 0, fetch_page_fault = 0 and in_ready = 0 during reset.
REQ-036 SHALL clear the storage array contents on reset, or treat them as don't-care because cnt = 0.
REQ-037 SHALL drive in_ready = 1 in the first cycle after reset deassertion unless pr_reset is asserted.
REQ-038 SHALL cleanly discard everything when reset asserts mid-operation; no partial state survives.

Verification
REQ-039 SHALL cover fill: push in_len = 8 with bytes 00..07, then 08..0F, with dec_acceptable = 0 -> cnt = 16, fetch_valid = 8, fetch = 0x0706050403020100, in_ready = 0.
REQ-040 SHALL cover simultaneous push and removal: with cnt = 5 and dec_acceptable = 3, push in_len = 4 -> next cnt = 6, byte 0 is the old byte 3, and the new bytes occupy positions 2..5.
REQ-041 SHALL cover a limit marker: push in_len = 2 with in_limit = 1, then dec_acceptable = 8 -> fetch_valid goes 2 -> 0, fetch_limit rises the cycle cnt reaches 0, in_ready stays 0.
REQ-042 SHALL cover a page fault: push in_len = 0 with in_page_fault = 1 and in_limit = 1 on an empty queue -> HALT_PF; fetch_page_fault = 1 and fetch_limit = 0 the next cycle.
REQ-043 SHALL cover flush: with cnt = 12 in HALT_LIMIT, assert pr_reset together with in_valid and dec_acceptable = 8 -> next cycle cnt = 0, state RUN, fetch_limit = 0, in_ready = 1.
REQ-044 SHALL cover async reset: assert rst_n = 0 mid-cycle with cnt = 9 -> fetch_valid = 0 immediately, without waiting for a clock edge.
